// File: rtl/axadd_eval_pkg.sv
// Shared types and helpers for the approximate-adder evaluation sequencer.
package axadd_eval_pkg;

  typedef enum logic [1:0] {IDLE, APPLY, CAPTURE, FINISH} state_t;

  // Settle counter holds SETTLE_CYCLES-1, and SETTLE_CYCLES is at most 15.
  localparam int SETTLE_W = 4;

  function automatic int op_w(input int n_in);
    return n_in / 2;
  endfunction

  function automatic int cnt_w(input int n_in);
    return n_in + 1;
  endfunction

  function automatic int tot_w(input int n_in, input int n_out);
    return n_in + n_out;
  endfunction

  function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
    return (a >= b) ? a - b : b - a;
  endfunction

endpackage

// File: rtl/axadd_eval_sequencer_if.sv
// Control and status bundle between the evaluation wrapper and the sequencer.
interface axadd_eval_sequencer_if #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 3
);
  logic                  start;
  logic                  abort;
  logic                  busy;
  logic                  done;
  logic                  aborted;
  logic                  pass;
  logic [N_OUT-1:0]      max_err;
  logic [N_IN-1:0]       wce_vec;
  logic [N_IN:0]         err_count;
  logic [N_OUT+N_IN-1:0] total_err;

  modport master (output start, abort,
                  input  busy, done, aborted, pass, max_err, wce_vec, err_count, total_err);
  modport slave  (input  start, abort,
                  output busy, done, aborted, pass, max_err, wce_vec, err_count, total_err);
endinterface

// File: rtl/axadd_err_accum.sv
// Exact-sum reference, absolute error and the running error statistics.
module axadd_err_accum
  import axadd_eval_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int N_OUT = 3,
  parameter int ET    = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         en,
  input  logic [N_IN-1:0]              vec,
  input  logic [N_OUT-1:0]             approx,
  output logic [N_OUT-1:0]             max_err,
  output logic [N_IN-1:0]              wce_vec,
  output logic [cnt_w(N_IN)-1:0]       err_count,
  output logic [tot_w(N_IN,N_OUT)-1:0] total_err
);
  localparam int OP_W = op_w(N_IN);

  logic [N_OUT-1:0] exact;
  logic [N_OUT-1:0] err;

  assign exact = N_OUT'(vec[OP_W-1:0]) + N_OUT'(vec[N_IN-1:OP_W]);
  assign err   = N_OUT'(abs_diff(32'(approx), 32'(exact)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_err   <= '0;
      wce_vec   <= '0;
      err_count <= '0;
      total_err <= '0;
    end else if (clr) begin
      max_err   <= '0;
      wce_vec   <= '0;
      err_count <= '0;
      total_err <= '0;
    end else if (en) begin
      total_err <= total_err + tot_w(N_IN,N_OUT)'(err);
      if (32'(err) > ET) err_count <= err_count + cnt_w(N_IN)'(1);
      // Strict compare: on ties the earliest vector stays recorded.
      if (err > max_err) begin
        max_err <= err;
        wce_vec <= vec;
      end
    end
  end
endmodule

// File: rtl/axadd_eval_sequencer.sv
// Sweeps every input vector through one approximate adder and grades its error.
module axadd_eval_sequencer
  import axadd_eval_pkg::*;
#(
  parameter int N_IN          = 4,
  parameter int N_OUT         = 3,
  parameter int ET            = 5,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  axadd_eval_sequencer_if.slave ctl,
  output logic [N_IN-1:0]  dut_in,
  input  logic [N_OUT-1:0] dut_out
);
  localparam logic [SETTLE_W-1:0] CNT_LD = SETTLE_W'(SETTLE_CYCLES - 1);

  state_t              state, state_nxt;
  logic [SETTLE_W-1:0] cnt;
  logic                busy_q, aborted_q, pass_q;
  logic                clr, acc_en;
  logic                last_vec;

  assign last_vec = &dut_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    acc_en    = 1'b0;
    case (state)
      IDLE: if (ctl.start) begin
        state_nxt = APPLY;
        clr       = 1'b1;
      end
      APPLY: begin
        if (ctl.abort)     state_nxt = FINISH;
        else if (cnt == '0) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        if (ctl.abort) state_nxt = FINISH;
        else begin
          acc_en    = 1'b1;
          state_nxt = last_vec ? FINISH : APPLY;
        end
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dut_in    <= '0;
      cnt       <= '0;
      busy_q    <= 1'b0;
      aborted_q <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (ctl.start) begin
          dut_in    <= '0;
          cnt       <= CNT_LD;
          busy_q    <= 1'b1;
          aborted_q <= 1'b0;
        end
        APPLY: begin
          if (ctl.abort)      aborted_q <= 1'b1;
          else if (cnt != '0) cnt <= cnt - 1'b1;
        end
        CAPTURE: begin
          if (ctl.abort) aborted_q <= 1'b1;
          else if (!last_vec) begin
            dut_in <= dut_in + 1'b1;
            cnt    <= CNT_LD;
          end
        end
        FINISH: begin
          busy_q <= 1'b0;
          pass_q <= (ctl.err_count == '0) && !aborted_q;
        end
        default: ;
      endcase
    end
  end

  axadd_err_accum #(.N_IN(N_IN), .N_OUT(N_OUT), .ET(ET)) u_accum (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .en        (acc_en),
    .vec       (dut_in),
    .approx    (dut_out),
    .max_err   (ctl.max_err),
    .wce_vec   (ctl.wce_vec),
    .err_count (ctl.err_count),
    .total_err (ctl.total_err)
  );

  assign ctl.busy    = busy_q;
  assign ctl.done    = (state == FINISH);
  assign ctl.aborted = aborted_q;
  assign ctl.pass    = pass_q;
endmodule

// File: tb/tb_axadd_eval_sequencer.sv
// Directed and randomized sweeps of the sequencer against a spec-level error model.
module tb_axadd_eval_sequencer;
  localparam int N_IN  = 4;
  localparam int N_OUT = 3;
  localparam int ET    = 5;
  localparam int S     = 1;
  localparam int NV    = 1 << N_IN;

  logic clk = 1'b0;
  logic rst;
  logic [N_IN-1:0]  dut_in;
  logic [N_OUT-1:0] dut_out;

  always #5 clk = ~clk;

  axadd_eval_sequencer_if #(.N_IN(N_IN), .N_OUT(N_OUT)) ctl ();

  axadd_eval_sequencer #(.N_IN(N_IN), .N_OUT(N_OUT), .ET(ET), .SETTLE_CYCLES(S)) dut (
    .clk     (clk),
    .rst     (rst),
    .ctl     (ctl),
    .dut_in  (dut_in),
    .dut_out (dut_out)
  );

  // Adder under test: 0 exact, 1 tied 0, 2 tied 7, 3 random lookup table.
  int mode;
  logic [N_OUT-1:0] lut [NV];

  always_comb begin
    dut_out = '0;
    case (mode)
      0: dut_out = {1'b0, dut_in[1:0]} + {1'b0, dut_in[3:2]};
      1: dut_out = '0;
      2: dut_out = '1;
      default: dut_out = lut[dut_in];
    endcase
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int approx_out(input int v);
    case (mode)
      0:       return (v % 4) + (v / 4);
      1:       return 0;
      2:       return 7;
      default: return int'(lut[v]);
    endcase
  endfunction

  // Statistics of the first nv vectors, straight from the error definition.
  task automatic model(input int nv, output int mx, output int wce, output int cnt, output int tot);
    int e;
    mx = 0; wce = 0; cnt = 0; tot = 0;
    for (int v = 0; v < nv; v++) begin
      e = approx_out(v) - ((v % 4) + (v / 4));
      if (e < 0) e = -e;
      tot += e;
      if (e > ET) cnt++;
      if (e > mx) begin mx = e; wce = v; end
    end
  endtask

  // abort_n/restart_n: cycle after the start edge to raise abort/start (0 = never).
  task automatic sweep(input string tag, input int abort_n, input int restart_n);
    int first_done, n_done, budget, nv, done_n;
    int mx, wce, cnt, tot;
    bit ab;
    ab     = (abort_n != 0);
    nv     = ab ? abort_n / (S + 1) - 1 : NV;
    done_n = ab ? abort_n + 1 : 1 + NV * (S + 1);
    budget = NV * (S + 1) + 6;
    model(nv, mx, wce, cnt, tot);
    @(negedge clk) ctl.start = 1'b1;
    @(posedge clk);
    first_done = -1;
    n_done = 0;
    for (int n = 1; n <= budget; n++) begin
      @(negedge clk);
      if (n == 1) chk({tag, ".busy_rise"}, ctl.busy, 1);
      if (ctl.done) begin
        n_done++;
        if (first_done < 0) first_done = n;
      end
      ctl.start = (n == restart_n);
      ctl.abort = (n == abort_n);
    end
    chk({tag, ".done_cycle"}, first_done, done_n);
    chk({tag, ".done_count"}, n_done, 1);
    chk({tag, ".busy_end"}, ctl.busy, 0);
    chk({tag, ".aborted"}, ctl.aborted, ab);
    chk({tag, ".pass"}, ctl.pass, (cnt == 0) && !ab);
    chk({tag, ".max_err"}, ctl.max_err, mx);
    chk({tag, ".wce_vec"}, ctl.wce_vec, wce);
    chk({tag, ".err_count"}, ctl.err_count, cnt);
    chk({tag, ".total_err"}, ctl.total_err, tot);
  endtask

  initial begin
    int v;
    rst = 1'b1;
    ctl.start = 1'b0;
    ctl.abort = 1'b0;
    mode = 0;
    repeat (2) @(negedge clk);
    chk("reset.outs", {dut_in, ctl.busy, ctl.done, ctl.aborted, ctl.pass,
                       ctl.max_err, ctl.wce_vec, ctl.err_count, ctl.total_err}, 0);
    rst = 1'b0;
    @(negedge clk);

    sweep("exact", 0, 0);

    // abort and a spurious cycle in IDLE change nothing
    ctl.abort = 1'b1;
    @(negedge clk) ctl.abort = 1'b0;
    @(negedge clk);
    chk("idle_abort.aborted", ctl.aborted, 0);
    chk("idle_abort.busy", ctl.busy, 0);
    chk("idle_abort.pass", ctl.pass, 1);

    mode = 1; sweep("tie0", 0, 0);
    mode = 2; sweep("tie7", 0, 0);
    mode = 0; sweep("abort5", 5 * (S + 1), 0);
    sweep("restart", 0, 10);

    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < NV; i++) lut[i] = N_OUT'($urandom_range(0, 7));
      mode = 3;
      sweep($sformatf("rand%0d", t), 0, 0);
    end
    v = $urandom_range(0, NV - 1);
    sweep("rand_abort", (v + 1) * (S + 1), 0);

    // asynchronous reset in the middle of an APPLY cycle
    mode = 2;
    @(negedge clk) ctl.start = 1'b1;
    @(posedge clk);
    @(negedge clk) ctl.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid.busy", ctl.busy, 1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst.outs", {dut_in, ctl.busy, ctl.done, ctl.aborted, ctl.pass,
                           ctl.max_err, ctl.wce_vec, ctl.err_count, ctl.total_err}, 0);
    chk("async_rst.state", dut.state, 0);
    @(negedge clk) rst = 1'b0;
    mode = 0;
    sweep("post_rst", 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
